result_writeback: RTL and testbench

RESULT_WRITEBACK -- requirements
Module: result_writeback

---
 rtl/result_writeback.sv | 123 ++++++++++++
 tb/tb_result_writeback.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback.sv
// Result write-back engine: captures eight 24-bit MAC results plus a base address,
// then streams them as zero-extended 32-bit words to memory with stall and abort support.
module result_writeback #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              Clr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0][23:0]  results,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned WORD_W    = 24;
  localparam int unsigned BUS_W     = 32;
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic                                abort_q, abort_d;
  logic                                capture_c;
  logic                                accept_c;
  logic [NUM_WORDS-1:0][WORD_W-1:0]    shadow_q;
  logic [ADDR_W-1:0]                   base_q;

  assign accept_c = mem_write & ~mem_waitrequest;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; Clr always outranks start, and an abort seen during a stall
  // is remembered so the held beat still completes exactly once.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    abort_d   = abort_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Clr && start) begin
          capture_c = 1'b1;
          idx_d     = '0;
          abort_d   = 1'b0;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = Clr ? IDLE : WRITE;
      end
      WRITE: begin
        if (accept_c) begin
          if (Clr || abort_q) begin
            abort_d = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
          end else if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (Clr) begin
          abort_d = 1'b1;
        end
      end
      DONE: begin
        if (Clr) begin
          state_d = IDLE;
        end else if (start) begin
          capture_c = 1'b1;
          idx_d     = '0;
          abort_d   = 1'b0;
          state_d   = CAPTURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture registers isolate the burst from later changes on the inputs
  always_ff @(posedge clk) begin
    if (capture_c) begin
      shadow_q <= results;
      base_q   <= base_addr;
    end
  end

  // Registered control and memory-bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      abort_q       <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      abort_q   <= abort_d;
      mem_write <= (state_d == WRITE);
      busy      <= (state_d == CAPTURE) || (state_d == WRITE);
      done      <= (state_d == DONE);
      if (state_d == WRITE) begin
        mem_address   <= base_q + ADDR_W'(idx_d) * ADDR_W'(STRIDE);
        mem_writedata <= BUS_W'(shadow_q[idx_d]);
      end
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Randomized and directed bench for result_writeback against a burst-level model
// (expected beat list derived from base, stride and captured results).
module tb_result_writeback;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              Clr;
  logic [31:0]       base_addr;
  logic [7:0][23:0]  results;
  logic [31:0]       mem_address;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_waitrequest;
  logic              busy;
  logic              done;

  result_writeback #(.ADDR_W(32), .STRIDE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Clr(Clr),
    .base_addr(base_addr), .results(results),
    .mem_address(mem_address), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          first_wr, done_cyc, stall_cycles;
  bit          done_seen;
  int          stall_beat = -1, stall_left = 0, stall_pct = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic [31:0] exp_base;
  logic [23:0] exp_res[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    first_wr = -1; done_cyc = -1; done_seen = 1'b0; stall_cycles = 0;
  endtask

  // Advance one cycle, drive waitrequest for the new cycle, then observe the bus
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (stall_left > 0 && mem_write && got_addr.size() == stall_beat) begin
      mem_waitrequest = 1'b1;
      stall_left--;
    end else begin
      mem_waitrequest = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
    end
    if (prev_stall) begin
      check("hold_wr", 32'(mem_write), 32'd1);
      check("hold_addr", mem_address, prev_addr);
      check("hold_data", mem_writedata, prev_data);
    end
    if (mem_write) begin
      if (first_wr < 0) first_wr = cyc;
      check("wr_busy", 32'(busy), 32'd1);
      if (!mem_waitrequest) begin
        got_addr.push_back(mem_address);
        got_data.push_back(mem_writedata);
        got_cyc.push_back(cyc);
      end else begin
        stall_cycles++;
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    prev_stall = mem_write && mem_waitrequest;
    prev_addr  = mem_address;
    prev_data  = mem_writedata;
  endtask

  task automatic load_model(input logic [31:0] base, input bit rnd);
    exp_base = base;
    for (int i = 0; i < 8; i++)
      exp_res[i] = rnd ? 24'($urandom) : 24'(32'h010000 + i);
  endtask

  // Present start for one cycle with the model's base/results; returns the start cycle
  task automatic launch(output int n);
    base_addr = exp_base;
    for (int i = 0; i < 8; i++) results[i] = exp_res[i];
    start = 1'b1;
    clear_obs();
    n = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_end(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done || !busy) break;
      step();
    end
    if (k == budget) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_burst(input int n, input int nbeats, input bit exp_done);
    logic [31:0] ea;
    check("n_beats", 32'(got_addr.size()), 32'(nbeats));
    for (int i = 0; i < nbeats && i < got_addr.size(); i++) begin
      ea = exp_base + 32'(i * 4);
      check($sformatf("addr%0d", i), got_addr[i], ea);
      check($sformatf("data%0d", i), got_data[i], {8'h00, exp_res[i]});
    end
    if (nbeats > 0) check("first_wr", 32'(first_wr), 32'(n + 2));
    if (exp_done) check("done_cyc", 32'(done_cyc), 32'(n + 10 + stall_cycles));
    else          check("no_done", 32'(done_seen), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; Clr = 1'b0; mem_waitrequest = 1'b0;
    base_addr = '0; results = '0;
    #12;
    check("rst_wr", 32'(mem_write), 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_data", mem_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step(); step();

    // Zero-wait reference burst
    load_model(32'h1000, 1'b0);
    launch(n);
    run_until_end(50);
    check_burst(n, 8, 1'b1);
    for (int i = 0; i < 8 && i < got_cyc.size(); i++)
      check($sformatf("beat_cyc%0d", i), 32'(got_cyc[i]), 32'(n + 2 + i));

    // Done holds; three-cycle stall on beat 2
    step(); step();
    check("done_hold", 32'(done), 32'd1);
    stall_beat = 2; stall_left = 3;
    launch(n);
    run_until_end(50);
    check_burst(n, 8, 1'b1);
    check("stall_len", 32'(stall_cycles), 32'd3);
    if (got_cyc.size() > 2) check("beat2_span", 32'(got_cyc[2] - got_cyc[1]), 32'd4);

    // Isolation: inputs corrupted right after capture
    load_model(32'h1000, 1'b0);
    launch(n);
    base_addr = 32'hDEAD0000;
    for (int i = 0; i < 8; i++) results[i] = 24'hFFFFFF;
    run_until_end(50);
    check_burst(n, 8, 1'b1);

    // Abort while beat 4 stalled
    stall_beat = 4; stall_left = 4;
    load_model(32'h3000, 1'b1);
    launch(n);
    for (int k = 0; k < 40; k++) begin
      if (mem_write && mem_waitrequest && got_addr.size() == 4) break;
      step();
    end
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    run_until_end(50);
    step(); step(); step();
    check_burst(n, 5, 1'b0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr", 32'(mem_write), 32'd0);

    // Address wrap
    load_model(32'hFFFFFFF8, 1'b1);
    launch(n);
    run_until_end(50);
    check_burst(n, 8, 1'b1);
    if (got_addr.size() > 2) check("wrap_addr2", got_addr[2], 32'h0);

    // Restart from DONE at 0x2000, with a start pulse during WRITE ignored
    load_model(32'h2000, 1'b1);
    launch(n);
    step(); step();
    base_addr = 32'h5555_0000;
    for (int i = 0; i < 8; i++) results[i] = 24'hABCDEF;
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_end(50);
    check_burst(n, 8, 1'b1);

    // Clr together with start in DONE: Clr wins
    clear_obs();
    Clr = 1'b1; start = 1'b1;
    step();
    Clr = 1'b0; start = 1'b0;
    step(); step(); step();
    check("clrstart_beats", 32'(got_addr.size()), 32'd0);
    check("clrstart_busy", 32'(busy), 32'd0);
    check("clrstart_done", 32'(done), 32'd0);

    // Clr during CAPTURE: no write issued
    load_model(32'h4000, 1'b1);
    launch(n);
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    step(); step(); step();
    check("capclr_beats", 32'(got_addr.size()), 32'd0);
    check("capclr_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a burst
    load_model(32'h6000, 1'b1);
    launch(n);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("mrst_wr", 32'(mem_write), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_addr", mem_address, 32'd0);
    #2;
    rst_n = 1'b1;
    prev_stall = 1'b0;
    clear_obs();
    step(); step(); step(); step();
    check("mrst_idle", 32'(got_addr.size()), 32'd0);
    check("mrst_done", 32'(done), 32'd0);

    // Randomized bursts with random stalls and restarts
    stall_pct = 30;
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        Clr = 1'b1;
        step();
        Clr = 1'b0;
      end
      for (int w = $urandom_range(0, 2); w > 0; w--) step();
      load_model($urandom, 1'b1);
      launch(n);
      run_until_end(400);
      check_burst(n, 8, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
